// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - traffic-light phase sequencer driving the Timer block; optional pedestrian walk phase under WALK_PHASE_EN
module traffic_phase_ctrl #(
   parameter int T_RED  = 2,
   parameter int T_MAIN = 8,
   parameter int T_SIDE = 5,
   parameter int T_YEL  = 3,
   parameter int T_WALK = 6
) (
   input  logic       clk,
   input  logic       Sync_Reset,
   input  logic       Expired,
   input  logic       Side_Sensor,
`ifdef WALK_PHASE_EN
   input  logic       Walk_Req,
   output logic       Walk_Light,
`endif
   output logic       Start_Timer,
   output logic [3:0] Value,
   output logic [2:0] Main_Lights,
   output logic [2:0] Side_Lights
);

   // Every duration must fit the Timer's 4-bit count and be non-zero
   if (T_RED  < 1 || T_RED  > 15 ||
       T_MAIN < 1 || T_MAIN > 15 ||
       T_SIDE < 1 || T_SIDE > 15 ||
       T_YEL  < 1 || T_YEL  > 15 ||
       T_WALK < 1 || T_WALK > 15) begin : g_duration_check
      $error("traffic_phase_ctrl: every duration parameter must be in 1..15");
   end

   // Timer values are the raw low nibble of each duration
   localparam logic [3:0] V_RED  = T_RED[3:0];
   localparam logic [3:0] V_MAIN = T_MAIN[3:0];
   localparam logic [3:0] V_SIDE = T_SIDE[3:0];
   localparam logic [3:0] V_YEL  = T_YEL[3:0];
`ifdef WALK_PHASE_EN
   localparam logic [3:0] V_WALK = T_WALK[3:0];
`endif

   // Lamp encodings, {R,Y,G}
   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   typedef enum logic [2:0] {
      RED_A,
      MAIN_G,
      MAIN_Y,
      RED_B,
`ifdef WALK_PHASE_EN
      WALK,
`endif
      SIDE_G,
      SIDE_Y
   } phase_t;

   // START issues the timer pulse, GUARD masks a stale Expired, WAIT samples it
   typedef enum logic [1:0] {
      START,
      GUARD,
      WAIT
   } sub_t;

   phase_t     phase;
   phase_t     phase_nxt;
   sub_t       sub;
   sub_t       sub_nxt;
   logic [2:0] main_nxt;
   logic [2:0] side_nxt;
   logic [3:0] value_nxt;
   logic       start_nxt;
   logic       req_side;
`ifdef WALK_PHASE_EN
   logic       walk_nxt;
   logic       req_walk;
`endif

   // Next phase/sub-state, plus the output values that go with it so outputs stay registered yet in step with the state
   always_comb begin
      phase_nxt = phase;
      sub_nxt   = sub;
      start_nxt = 1'b0;
      main_nxt  = LAMP_R;
      side_nxt  = LAMP_R;
      value_nxt = V_RED;
`ifdef WALK_PHASE_EN
      walk_nxt  = 1'b0;
`endif

      case (sub)
         START: begin
            // START without a pulse on the outputs only happens straight out of reset:
            // stay one more cycle so the first phase still gets its pulse.
            if (Start_Timer) begin
               sub_nxt = GUARD;
            end
         end
         GUARD: begin
            sub_nxt = WAIT;
         end
         WAIT: begin
            if (Expired) begin
               sub_nxt = START;
               case (phase)
                  RED_A: phase_nxt = MAIN_G;
                  MAIN_G: begin
                     // No demand: phase stays MAIN_G and simply re-arms the timer
`ifdef WALK_PHASE_EN
                     if (req_side || req_walk) begin
                        phase_nxt = MAIN_Y;
                     end
`else
                     if (req_side) begin
                        phase_nxt = MAIN_Y;
                     end
`endif
                  end
                  MAIN_Y: phase_nxt = RED_B;
                  RED_B: begin
`ifdef WALK_PHASE_EN
                     phase_nxt = req_walk ? WALK : SIDE_G;
`else
                     phase_nxt = SIDE_G;
`endif
                  end
`ifdef WALK_PHASE_EN
                  WALK:   phase_nxt = SIDE_G;
`endif
                  SIDE_G: phase_nxt = SIDE_Y;
                  SIDE_Y: phase_nxt = RED_A;
                  default: phase_nxt = RED_A;
               endcase
            end
         end
         default: begin
            sub_nxt = START;
         end
      endcase

      start_nxt = (sub_nxt == START);

      case (phase_nxt)
         RED_A: begin
            value_nxt = V_RED;
         end
         MAIN_G: begin
            main_nxt  = LAMP_G;
            value_nxt = V_MAIN;
         end
         MAIN_Y: begin
            main_nxt  = LAMP_Y;
            value_nxt = V_YEL;
         end
         RED_B: begin
            value_nxt = V_RED;
         end
`ifdef WALK_PHASE_EN
         WALK: begin
            walk_nxt  = 1'b1;
            value_nxt = V_WALK;
         end
`endif
         SIDE_G: begin
            side_nxt  = LAMP_G;
            value_nxt = V_SIDE;
         end
         SIDE_Y: begin
            side_nxt  = LAMP_Y;
            value_nxt = V_YEL;
         end
         default: begin
            value_nxt = V_RED;
         end
      endcase
   end

   // State and output registers; reset drops straight to all-red with no intermediate colour
   always_ff @(posedge clk) begin
      if (Sync_Reset) begin
         phase       <= RED_A;
         sub         <= START;
         Start_Timer <= 1'b0;
         Value       <= V_RED;
         Main_Lights <= LAMP_R;
         Side_Lights <= LAMP_R;
`ifdef WALK_PHASE_EN
         Walk_Light  <= 1'b0;
`endif
      end else begin
         phase       <= phase_nxt;
         sub         <= sub_nxt;
         Start_Timer <= start_nxt;
         Value       <= value_nxt;
         Main_Lights <= main_nxt;
         Side_Lights <= side_nxt;
`ifdef WALK_PHASE_EN
         Walk_Light  <= walk_nxt;
`endif
      end
   end

   // Side-road demand latch; the clear at SIDE_G entry beats a coincident sensor
   always_ff @(posedge clk) begin
      if (Sync_Reset) begin
         req_side <= 1'b0;
      end else if (phase == SIDE_G && sub == START) begin
         req_side <= 1'b0;
      end else if (Side_Sensor) begin
         req_side <= 1'b1;
      end
   end

`ifdef WALK_PHASE_EN
   // Pedestrian demand latch; the clear at WALK entry beats a coincident button press
   always_ff @(posedge clk) begin
      if (Sync_Reset) begin
         req_walk <= 1'b0;
      end else if (phase == WALK && sub == START) begin
         req_walk <= 1'b0;
      end else if (Walk_Req) begin
         req_walk <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl (WALK_PHASE_EN optional)
module tb_traffic_phase_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   localparam int P_RED_A  = 0;
   localparam int P_MAIN_G = 1;
   localparam int P_MAIN_Y = 2;
   localparam int P_RED_B  = 3;
   localparam int P_WALK   = 4;
   localparam int P_SIDE_G = 5;
   localparam int P_SIDE_Y = 6;

   logic       clk;
   logic       Sync_Reset;
   logic       Expired;
   logic       Side_Sensor;
   logic       Start_Timer;
   logic [3:0] Value;
   logic [2:0] Main_Lights;
   logic [2:0] Side_Lights;
`ifdef WALK_PHASE_EN
   logic       Walk_Req;
   logic       Walk_Light;
`endif

   traffic_phase_ctrl dut (
      .clk         (clk),
      .Sync_Reset  (Sync_Reset),
      .Expired     (Expired),
      .Side_Sensor (Side_Sensor),
`ifdef WALK_PHASE_EN
      .Walk_Req    (Walk_Req),
      .Walk_Light  (Walk_Light),
`endif
      .Start_Timer (Start_Timer),
      .Value       (Value),
      .Main_Lights (Main_Lights),
      .Side_Lights (Side_Lights)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Phase table of the reference model: lamps, walk lamp and timer value per phase
   logic [2:0] ph_main  [7];
   logic [2:0] ph_side  [7];
   logic       ph_walk  [7];
   logic [3:0] ph_value [7];

   // Reference model: phase index, cycles since the phase's timer pulse (-1 = not yet pulsed after reset), demand flags
   int m_phase;
   int m_age;
   bit m_rs;
   bit m_rw;

   typedef struct {
      bit         rst;
      bit         sens;
      bit         exp;
      bit         start;
      logic [3:0] value;
      logic [2:0] main;
      logic [2:0] side;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int successor(input int p, input bit rs, input bit rw);
      case (p)
         P_RED_A:  return P_MAIN_G;
         P_MAIN_G: return (rs || rw) ? P_MAIN_Y : P_MAIN_G;
         P_MAIN_Y: return P_RED_B;
         P_RED_B:  return rw ? P_WALK : P_SIDE_G;
         P_WALK:   return P_SIDE_G;
         P_SIDE_G: return P_SIDE_Y;
         default:  return P_RED_A;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit sens, input bit exp, input bit walk);
      bit nrs;
      bit nrw;
      if (rst) begin
         m_phase = P_RED_A;
         m_age   = -1;
         m_rs    = 1'b0;
         m_rw    = 1'b0;
      end else begin
         nrs = (m_phase == P_SIDE_G && m_age == 0) ? 1'b0 : (m_rs | sens);
         nrw = (m_phase == P_WALK && m_age == 0) ? 1'b0 : (m_rw | walk);
         if (m_age >= 2 && exp) begin
            m_phase = successor(m_phase, m_rs, m_rw);
            m_age   = 0;
         end else if (m_age < 2) begin
            m_age++;
         end
         m_rs = nrs;
         m_rw = nrw;
      end
   endtask

   // Apply one cycle of inputs, advance the model, and compare every output half a cycle after the edge
   task automatic step(input bit rst, input bit sens, input bit exp, input bit walk);
      Sync_Reset  = rst;
      Side_Sensor = sens;
      Expired     = exp;
`ifdef WALK_PHASE_EN
      Walk_Req    = walk;
`endif
      model_step(rst, sens, exp, walk);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("start",  32'(Start_Timer), 32'(m_age == 0));
      check("value",  32'(Value),       32'(ph_value[m_phase]));
      check("main",   32'(Main_Lights), 32'(ph_main[m_phase]));
      check("side",   32'(Side_Lights), 32'(ph_side[m_phase]));
`ifdef WALK_PHASE_EN
      check("walk",   32'(Walk_Light),  32'(ph_walk[m_phase]));
`endif
      check("main_onehot", 32'($onehot(Main_Lights)), 32'd1);
      check("side_onehot", 32'($onehot(Side_Lights)), 32'd1);
      check("one_road_go", 32'(Main_Lights == R || Side_Lights == R), 32'd1);
   endtask

   task automatic add(input bit rst, input bit sens, input bit exp, input bit start,
                      input logic [3:0] value, input logic [2:0] main, input logic [2:0] side,
                      input int reps);
      vec_t v;
      v.rst = rst; v.sens = sens; v.exp = exp;
      v.start = start; v.value = value; v.main = main; v.side = side;
      for (int k = 0; k < reps; k++) vecs.push_back(v);
   endtask

   initial begin
      bit found;
      int last_pulse;

      ph_main  = '{R, G, Y, R, R, R, R};
      ph_side  = '{R, R, R, R, R, G, Y};
      ph_walk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ph_value = '{4'd2, 4'd8, 4'd3, 4'd2, 4'd6, 4'd5, 4'd3};

      Sync_Reset  = 1'b1;
      Expired     = 1'b0;
      Side_Sensor = 1'b0;
`ifdef WALK_PHASE_EN
      Walk_Req    = 1'b0;
`endif
      m_phase = P_RED_A;
      m_age   = -1;
      m_rs    = 1'b0;
      m_rw    = 1'b0;

      // Directed table: reset, MAIN_G re-arm, one side demand through the full cycle, then re-arm again
      //   rst sens exp  start val main side reps
      add(1, 0, 0,  0, 2, R, R, 3);   // held reset
      add(0, 0, 0,  1, 2, R, R, 1);   // RED_A pulse right after release
      add(0, 0, 1,  0, 2, R, R, 2);   // stale Expired ignored in START/GUARD
      add(0, 0, 1,  1, 8, G, R, 1);   // MAIN_G
      add(0, 0, 0,  0, 8, G, R, 3);
      add(0, 0, 1,  1, 8, G, R, 1);   // re-arm, no demand
      add(0, 1, 0,  0, 8, G, R, 1);   // one-cycle side pulse
      add(0, 0, 0,  0, 8, G, R, 1);
      add(0, 0, 1,  1, 3, Y, R, 1);   // MAIN_Y
      add(0, 0, 0,  0, 3, Y, R, 2);
      add(0, 0, 1,  1, 2, R, R, 1);   // RED_B
      add(0, 0, 0,  0, 2, R, R, 2);
      add(0, 0, 1,  1, 5, R, G, 1);   // SIDE_G
      add(0, 0, 0,  0, 5, R, G, 2);
      add(0, 0, 1,  1, 3, R, Y, 1);   // SIDE_Y
      add(0, 0, 0,  0, 3, R, Y, 2);
      add(0, 0, 1,  1, 2, R, R, 1);   // RED_A
      add(0, 0, 0,  0, 2, R, R, 2);
      add(0, 0, 1,  1, 8, G, R, 1);   // MAIN_G
      add(0, 0, 0,  0, 8, G, R, 2);
      add(0, 0, 1,  1, 8, G, R, 1);   // demand was consumed: re-arm

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].sens, vecs[i].exp, 1'b0);
         check("tbl_start", 32'(Start_Timer), 32'(vecs[i].start));
         check("tbl_value", 32'(Value),       32'(vecs[i].value));
         check("tbl_main",  32'(Main_Lights), 32'(vecs[i].main));
         check("tbl_side",  32'(Side_Lights), 32'(vecs[i].side));
      end

      // Expired held high from reset: exactly one phase entry every 3 cycles
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      last_pulse = -1;
      for (int i = 0; i < 45; i++) begin
         step(0, i == 4, 1, 0);
         if (Start_Timer) begin
            if (last_pulse >= 0) check("stale_gap", 32'(cyc - last_pulse), 32'd3);
            last_pulse = cyc;
         end
      end
      check("stale_saw_pulses", 32'(last_pulse >= 0), 32'd1);

      // Reset in SIDE_G/WAIT goes straight to all-red
      step(1, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(0, i == 0, 1, 0);
         if (Start_Timer && Side_Lights == G) found = 1'b1;
      end
      check("reach_side_g", 32'(found), 32'd1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("side_g_wait", 32'(Side_Lights), 32'(G));
      step(1, 0, 0, 0);
      check("midrst_side", 32'(Side_Lights), 32'(R));
      check("midrst_main", 32'(Main_Lights), 32'(R));
      check("midrst_value", 32'(Value), 32'd2);
      step(0, 0, 0, 0);
      check("midrst_restart", 32'(Start_Timer), 32'd1);

`ifdef WALK_PHASE_EN
      // Pedestrian request alone ends MAIN_G and inserts WALK before SIDE_G
      step(1, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(0, 0, 1, i == 5);
         if (Start_Timer && Walk_Light) found = 1'b1;
      end
      check("reach_walk", 32'(found), 32'd1);
      check("walk_value", 32'(Value), 32'd6);
      check("walk_lamps", 32'({Main_Lights, Side_Lights}), 32'({R, R}));
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("after_walk_side", 32'(Side_Lights), 32'(G));
      check("after_walk_lamp", 32'(Walk_Light), 32'd0);
`endif

      // Randomized traffic against the reference model
      step(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 1) == 1,
`ifdef WALK_PHASE_EN
              $urandom_range(0, 19) == 0);
`else
              1'b0);
`endif
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
